// File: rtl/output_display.sv
// Decimal display driver: captures the CPU output register, converts it to BCD with a
// sequential double-dabble engine and scans a 4-digit multiplexed 7-segment display.
module output_display #(
    parameter int unsigned REFRESH_DIV = 4
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic [7:0]  display_data,
    input  logic        out_load,
    input  logic        signed_mode,
    output logic [11:0] bcd,
    output logic        neg,
    output logic        busy,
    output logic [6:0]  seg,
    output logic [3:0]  an
);

    localparam logic [15:0] PrescMax = 16'(REFRESH_DIV - 1);

    typedef enum logic {StIdle, StConv} state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q;
    logic [7:0]  shift_q;
    logic [11:0] scratch_q;
    logic        neg_next_q;
    logic        pend_valid_q;
    logic [7:0]  pend_data_q;
    logic        pend_signed_q;
    logic [11:0] bcd_q;
    logic        neg_q;
    logic [15:0] presc_q;
    logic [1:0]  idx_q;
    logic [3:0]  an_q, an_d;
    logic [6:0]  seg_q, seg_d;

    logic        start;
    logic [7:0]  src_data;
    logic        src_signed;
    logic        src_neg;
    logic [7:0]  mag;
    logic [11:0] adj;
    logic [11:0] scratch_next;
    logic [7:0]  shift_next;
    logic        unused_adj_msb;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // A direct load wins over a pending value; either way pending is consumed.
    always_comb begin
        start      = (state_q == StIdle) && (out_load || pend_valid_q);
        src_data   = out_load ? display_data : pend_data_q;
        src_signed = out_load ? signed_mode : pend_signed_q;
        src_neg    = src_signed && src_data[7];
        mag        = src_neg ? 8'(~src_data + 8'd1) : src_data;
    end

    always_comb begin
        adj            = {add3(scratch_q[11:8]), add3(scratch_q[7:4]), add3(scratch_q[3:0])};
        scratch_next   = {adj[10:0], shift_q[7]};
        shift_next     = {shift_q[6:0], 1'b0};
        unused_adj_msb = adj[11];
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StConv;
            StConv:  if (cnt_q == 3'd7) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            cnt_q         <= 3'd0;
            shift_q       <= 8'd0;
            scratch_q     <= 12'd0;
            neg_next_q    <= 1'b0;
            pend_valid_q  <= 1'b0;
            pend_data_q   <= 8'd0;
            pend_signed_q <= 1'b0;
            bcd_q         <= 12'd0;
            neg_q         <= 1'b0;
        end else if (start) begin
            cnt_q        <= 3'd0;
            shift_q      <= mag;
            scratch_q    <= 12'd0;
            neg_next_q   <= src_neg;
            pend_valid_q <= 1'b0;
        end else if (state_q == StConv) begin
            cnt_q     <= cnt_q + 3'd1;
            shift_q   <= shift_next;
            scratch_q <= scratch_next;
            if (cnt_q == 3'd7) begin
                bcd_q <= scratch_next;
                neg_q <= neg_next_q;
            end
            if (out_load) begin
                pend_valid_q  <= 1'b1;
                pend_data_q   <= display_data;
                pend_signed_q <= signed_mode;
            end
        end
    end

    // Decode uses only the published result so partial conversions never show.
    always_comb begin
        an_d = 4'b0001 << idx_q;
        unique case (idx_q)
            2'd0:    seg_d = seg_of(bcd_q[3:0]);
            2'd1:    seg_d = (bcd_q[11:4] == 8'd0) ? 7'h00 : seg_of(bcd_q[7:4]);
            2'd2:    seg_d = (bcd_q[11:8] == 4'd0) ? 7'h00 : seg_of(bcd_q[11:8]);
            default: seg_d = neg_q ? 7'h40 : 7'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            presc_q <= 16'd0;
            idx_q   <= 2'd0;
            an_q    <= 4'b0001;
            seg_q   <= 7'h3F;
        end else begin
            if (presc_q == PrescMax) begin
                presc_q <= 16'd0;
                idx_q   <= idx_q + 2'd1;
            end else begin
                presc_q <= presc_q + 16'd1;
            end
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign bcd  = bcd_q;
    assign neg  = neg_q;
    assign busy = (state_q == StConv);
    assign seg  = seg_q;
    assign an   = an_q;

endmodule
